// File: rtl/bit_serial_alu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bit_serial_alu_ctrl                                        |
// | Description : Sequencer for a 1-bit ALU slice; runs a WIDTH-bit op LSB   |
// |               first, one bit per clock, and assembles result and flags.  |
// |               Define ALU_OVF_EN to add the signed-overflow port.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] c_op_and  = 3'b000;
    localparam logic [2:0] c_op_or   = 3'b001;
    localparam logic [2:0] c_op_xor  = 3'b010;
    localparam logic [2:0] c_op_not  = 3'b011;
    localparam logic [2:0] c_op_add  = 3'b100;
    localparam logic [2:0] c_op_sub  = 3'b101;
    localparam logic [2:0] c_op_nand = 3'b110;
    localparam logic [2:0] c_op_nor  = 3'b111;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;

    logic             w_arith;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sum;
    logic             w_cout;
    logic             w_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Bit-cell slice: SUB is a + ~b + 1, the +1 comes from the preset carry flop.
    always_comb begin
        w_arith = (r_op == c_op_add) || (r_op == c_op_sub);
        w_a_bit = r_a_sr[0];
        w_b_bit = r_b_sr[0] ^ (r_op == c_op_sub);
        w_sum   = w_a_bit ^ w_b_bit ^ r_carry;
        w_cout  = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));
        case (r_op)
            c_op_and:  w_bit = w_a_bit & w_b_bit;
            c_op_or:   w_bit = w_a_bit | w_b_bit;
            c_op_xor:  w_bit = w_a_bit ^ w_b_bit;
            c_op_not:  w_bit = ~w_a_bit;
            c_op_nand: w_bit = ~(w_a_bit & w_b_bit);
            c_op_nor:  w_bit = ~(w_a_bit | w_b_bit);
            default:   w_bit = w_sum;
        endcase
        w_res_next = {w_bit, r_res_sr[WIDTH-1:1]};
        w_last     = (r_state == S_RUN) && (r_cnt == c_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_res_sr  <= '0;
            r_op      <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_op    <= opcode;
                        r_cnt   <= '0;
                        r_carry <= (opcode == c_op_sub);
                        r_state <= S_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_arith) begin
                        r_carry <= w_cout;
                    end
                    // Visible outputs change only on the final step.
                    if (w_last) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= w_res_next;
                        carry_out <= w_arith & w_cout;
                        zero      <= (w_res_next == '0);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_OVF_EN
    // Signed overflow: carry into MSB (flop) versus carry out of MSB on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (w_last) begin
            overflow <= w_arith & (r_carry ^ w_cout);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
`default_nettype none
// Scoreboard bench for bit_serial_alu_ctrl (WIDTH=8): directed ops, reset abort,
// ignored start during RUN and back-to-back issue spacing.
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         start  = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
`ifdef ALU_OVF_EN
    logic         overflow;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    int   last_acc = 0;
    logic busy_q   = 1'b0;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
`ifdef ALU_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_XOR:  e.res = x ^ y;
            OP_NOT:  e.res = ~x;
            OP_NAND: e.res = ~(x & y);
            OP_NOR:  e.res = ~(x | y);
            OP_ADD: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            default: begin
                s     = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records accept cycles and checks every done against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (busy && !busy_q) begin
            acc_q.push_back(cyc);
            last_acc = cyc;
        end
        busy_q = busy;
        if (done) begin
            n_done++;
            chk("latency", 32'(cyc - last_acc), 32'(W));
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry_out", 32'(carry_out), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.z));
`ifdef ALU_OVF_EN
                chk("overflow", 32'(overflow), 32'(e.v));
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        opcode = op;
        a      = x;
        b      = y;
        start  = 1'b1;
        sb.push_back(model(op, x, y));
        tick();
        start  = 1'b0;
        opcode = ~op;
        a      = ~x;
        b      = ~y;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_carry"}, 32'(carry_out), 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
`ifdef ALU_OVF_EN
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
`endif
    endtask

    initial begin
        int prev;
        int base;
        int n;

        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        issue(OP_ADD, 8'h7F, 8'h01);  drain();
        issue(OP_SUB, 8'h05, 8'h05);  drain();
        issue(OP_SUB, 8'h03, 8'h05);  drain();
        issue(OP_NOT, 8'hA5, 8'h00);  drain();
        issue(OP_XOR, 8'hF0, 8'h3C);  drain();
        issue(OP_NOR, 8'h0F, 8'hF0);  drain();
        issue(OP_AND, 8'hC3, 8'h5A);  drain();
        issue(OP_OR,  8'h81, 8'h18);  drain();
        issue(OP_NAND, 8'hFF, 8'hFF); drain();
        issue(OP_ADD, 8'hFF, 8'h02);  drain();
        issue(OP_SUB, 8'h80, 8'h01);  drain();

        // Result and flags must hold through IDLE.
        repeat (3) tick();
        chk("hold_result", 32'(result), 32'h7F);
        chk("hold_ready", 32'(ready), 32'd1);

        // start held with new operands during RUN is ignored.
        prev   = n_done;
        opcode = OP_ADD;
        a      = 8'h10;
        b      = 8'h20;
        start  = 1'b1;
        sb.push_back(model(OP_ADD, 8'h10, 8'h20));
        tick();
        opcode = OP_SUB;
        a      = 8'h55;
        b      = 8'h66;
        repeat (6) tick();
        start = 1'b0;
        drain();
        repeat (4) tick();
        chk("single_done", 32'(n_done - prev), 32'd1);

        // Reset during RUN aborts the op with no done.
        issue(OP_SUB, 8'h40, 8'h11);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        sb.delete();
        prev = n_done;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("abort_no_done", 32'(n_done - prev), 32'd0);
        issue(OP_ADD, 8'h33, 8'h44);
        drain();

        // Back-to-back issue with start held high.
        base   = acc_q.size();
        opcode = OP_OR;
        a      = 8'h0C;
        b      = 8'h30;
        start  = 1'b1;
        sb.push_back(model(OP_OR, 8'h0C, 8'h30));
        tick();
        opcode = OP_SUB;
        a      = 8'h10;
        b      = 8'h20;
        sb.push_back(model(OP_SUB, 8'h10, 8'h20));
        n = 0;
        while (acc_q.size() < base + 2 && n < 30) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk("b2b_accepts", 32'(acc_q.size() - base), 32'd2);
        if (acc_q.size() >= base + 2) begin
            chk("b2b_spacing", 32'(acc_q[base+1] - acc_q[base]), 32'(W + 2));
        end
        drain();
        repeat (4) tick();
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
